// File: rtl/inst_mem_responder.sv
// Instruction-memory responder: byte-serial program load feeding a pipelined, field-split fetch port.
// Optional macro LOAD_CHECKSUM_EN treats the load_last byte as a mod-256 checksum of the stored bytes.
module inst_mem_responder #(
    parameter int DEPTH  = 256,
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              load_start,
    input  logic              load_valid,
    input  logic [DATA_W-1:0] load_data,
    input  logic              load_last,
    output logic              load_ready,
    output logic              load_done,
    output logic              load_err,
    output logic              busy,
    input  logic              fetch_req,
    input  logic [ADDR_W-1:0] fetch_addr,
    output logic              fetch_ack,
    output logic [DATA_W-1:0] fetch_data,
    output logic [2:0]        opcode,
    output logic [1:0]        rs_inst,
    output logic [4:0]        low5_bits
);

    typedef enum logic [1:0] {IDLE, LOAD, RUN} state_t;

    state_t            state;
    state_t            state_nxt;
    logic [ADDR_W-1:0] ptr;
    logic [ADDR_W-1:0] wr_addr;
    logic              wr_en;
    logic              wr_end;
    logic              done_nxt;
    logic              err_set;
    logic              accept_p0;
    logic              vld_p1;
    logic [DATA_W-1:0] data_p1;

    logic [DATA_W-1:0] mem [DEPTH];

    // A load_start inside LOAD restarts the pointer, so that cycle's byte lands at address 0.
    assign wr_addr = load_start ? '0 : ptr;
    assign wr_end  = (wr_addr == ADDR_W'(DEPTH - 1));

`ifdef LOAD_CHECKSUM_EN
    logic [DATA_W-1:0] sum;
    logic [DATA_W-1:0] sum_base;
    logic              cks_ok;

    assign sum_base = load_start ? '0 : sum;
    assign cks_ok   = (load_data == sum_base);
    assign wr_en    = (state == LOAD) && load_valid && !load_last;
`else
    assign wr_en    = (state == LOAD) && load_valid;
`endif

    always_comb begin
        state_nxt = state;
        done_nxt  = 1'b0;
        err_set   = 1'b0;
        case (state)
            IDLE: if (load_start) state_nxt = LOAD;
            RUN:  if (load_start) state_nxt = LOAD;
            LOAD: begin
                if (load_valid && load_last) begin
`ifdef LOAD_CHECKSUM_EN
                    if (cks_ok) begin
                        state_nxt = RUN;
                        done_nxt  = 1'b1;
                    end else begin
                        state_nxt = IDLE;
                        err_set   = 1'b1;
                    end
`else
                    state_nxt = RUN;
                    done_nxt  = 1'b1;
`endif
                end else if (load_valid && wr_end) begin
                    state_nxt = RUN;
                    done_nxt  = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            ptr       <= '0;
            load_done <= 1'b0;
        end else begin
            state     <= state_nxt;
            load_done <= done_nxt;
            if (wr_en)
                ptr <= wr_addr + 1'b1;
            else if (load_start)
                ptr <= '0;
        end
    end

`ifdef LOAD_CHECKSUM_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sum      <= '0;
            load_err <= 1'b0;
        end else begin
            sum <= sum_base + (wr_en ? load_data : '0);
            if (load_start)
                load_err <= 1'b0;
            else if (err_set)
                load_err <= 1'b1;
        end
    end
`else
    assign load_err = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (wr_en)
            mem[wr_addr] <= load_data;
    end

    // Stage p0 -> p1: request accepted only in RUN and never alongside load_start.
    assign accept_p0 = (state == RUN) && fetch_req && !load_start;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            vld_p1  <= 1'b0;
            data_p1 <= '0;
        end else begin
            vld_p1 <= accept_p0;
            if (accept_p0)
                data_p1 <= mem[fetch_addr];
        end
    end

    assign fetch_ack  = vld_p1;
    assign fetch_data = data_p1;
    assign opcode     = data_p1[7:5];
    assign rs_inst    = data_p1[4:3];
    assign low5_bits  = data_p1[4:0];
    assign load_ready = (state == LOAD);
    assign busy       = (state != RUN);

endmodule

// File: doc/inst_mem_responder.md
Name: inst_mem_responder

Overview:
Instruction-memory responder serving the fetch stage of the 8-bit processor. It answers fetch requests with the instruction byte and returns that byte pre-split into opcode, Rs and low-5 fields.
Memory contents come from a byte-serial program-load port. Fetch is refused until a load completes. The block sits between the program loader and the IF stage.

Parameters:
DEPTH, 256, number of instruction bytes; must be 2^ADDR_W
ADDR_W, 8, fetch and load address width
DATA_W, 8, instruction width; field split is defined for 8 only

Ports:
clk  in  1  system clock, rising edge
reset_n  in  1  asynchronous active-low reset
load_start  in  1  one-cycle pulse: begin a new program load
load_valid  in  1  load_data valid this cycle
load_data  in  DATA_W  program byte
load_last  in  1  marks the final byte; qualified by load_valid
load_ready  out  1  high while in LOAD
load_done  out  1  one-cycle pulse on entry to RUN
load_err  out  1  checksum failure, sticky (optional feature only)
busy  out  1  high when state != RUN
fetch_req  in  1  fetch request, sampled each cycle
fetch_addr  in  ADDR_W  instruction address (PC)
fetch_ack  out  1  response valid, one cycle
fetch_data  out  DATA_W  instruction byte
opcode  out  3  fetch_data[7:5]
rs_inst  out  2  fetch_data[4:3]
low5_bits  out  5  fetch_data[4:0]

Behaviour:
- Reset (asynchronous, reset_n=0):
  - state=IDLE, write pointer=0.
  - load_ready, load_done, load_err, fetch_ack=0; busy=1.
  - fetch_data, opcode, rs_inst, low5_bits=0.
  - Memory array is not cleared.
- States IDLE, LOAD, RUN.
  - IDLE->LOAD on load_start.
  - RUN->LOAD on load_start.
  - LOAD ignores load_start, except that it restarts the pointer at 0.
- LOAD:
  - load_ready=1.
  - Each cycle with load_valid: mem[ptr]<=load_data, ptr<=ptr+1.
  - load_valid&load_last: byte written, next state RUN, load_done pulses the following cycle.
  - A write to address DEPTH-1 without load_last also ends the load (RUN, load_done); the pointer never wraps.
- RUN, fetch:
  - fetch_req sampled at edge N gives fetch_ack=1 at N+1, with fetch_data=mem[fetch_addr sampled at N] and the field outputs derived from it.
  - Fully pipelined: a req every cycle gives an ack every cycle.
  - Data and field outputs hold their last value when fetch_ack=0.
- IDLE or LOAD: fetch_req is ignored, no ack, outputs hold.
- A request in the same cycle as load_start is dropped.
- An ack already scheduled from the previous cycle is still delivered.
- Reset mid-load abandons the load; the block requires a fresh load before fetch.
- A read in the cycle a byte is written to the same address returns the old byte.

Optional Feature:
- Macro LOAD_CHECKSUM_EN.
- When defined:
  - The load_last byte is an 8-bit checksum and is not stored.
  - The block keeps a running sum mod 256 of stored bytes, cleared on load_start.
  - Match: RUN and load_done.
  - Mismatch: IDLE and load_err=1, cleared on the next load_start.
  - The DEPTH-1 auto-end skips the check and passes.
- When undefined: the last byte is stored as data and load_err is tied to 0.

Test Plan:
1. Reset, then fetch_req=1 addr 0x00 for 3 cycles -> fetch_ack stays 0, busy=1.
2. Load bytes 0xA5,0x3C,0xFF (last on 0xFF) -> load_done one cycle after last; fetch addr 1 -> ack next cycle, data 0x3C, opcode=3'b001, rs_inst=2'b11, low5_bits=5'b11100.
3. Back-to-back fetch addrs 0,1,2 on consecutive cycles -> acks on 3 consecutive cycles with 0xA5,0x3C,0xFF.
4. Stream 256 bytes with no load_last -> load auto-ends after address 0xFF, load_done pulses, mem[0xFF] correct.
5. Assert reset_n=0 mid-load after 2 bytes -> outputs zero immediately, state IDLE, fetch not acked until a new load completes.
6. With LOAD_CHECKSUM_EN: load 0x10,0x20 then last 0x30 -> RUN; repeat with last 0x31 -> load_err=1, busy=1, fetches not acked.
